// File: rtl/ame_pkg.sv
// Purpose : shared types and default sizes for the AME pivot controller slice.
// Latency : n/a (declarations only).
// Backpressure: n/a.
// Contents: element/index/column sizes, row type, controller state enum.
package ame_pkg;

  localparam int COMP_DATA_BITS     = 64;  // signed matrix element width
  localparam int COMP_DATA_IDX_BITS = 3;   // comparator row-index width
  localparam int MAT_COLS           = 7;   // 6x6 system plus RHS column
  localparam int MAT_ROWS           = 6;

  typedef logic [MAT_COLS*COMP_DATA_BITS-1:0] row_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_SWAP,
    ST_FIN
  } state_t;

endpackage

// File: rtl/ame_mat_regfile.sv
// Purpose : 6-row matrix store with one write port, one read port and a row-swap port.
// Latency : write/swap take effect on the next rising edge; reads are combinational.
// Backpressure: none; write has priority over swap when both are requested.
// Ports: wr_en/wr_row/wr_data (row write), rd_row/rd_data (row read),
//        swap_en/swap_a/swap_b (exchange two rows), col_sel/col_data (one column of all rows).
module ame_mat_regfile
  import ame_pkg::*;
#(
  parameter int COL_BITS = COMP_DATA_BITS,
  parameter int N_COLS   = MAT_COLS
) (
  input  logic                         clk_i,
  input  logic                         rst_n_i,
  input  logic                         wr_en,
  input  logic [2:0]                   wr_row,
  input  logic [N_COLS*COL_BITS-1:0]   wr_data,
  input  logic [2:0]                   rd_row,
  output logic [N_COLS*COL_BITS-1:0]   rd_data,
  input  logic                         swap_en,
  input  logic [2:0]                   swap_a,
  input  logic [2:0]                   swap_b,
  input  logic [2:0]                   col_sel,
  output logic [MAT_ROWS*COL_BITS-1:0] col_data
);

  logic [N_COLS*COL_BITS-1:0] mem [MAT_ROWS];

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      for (int r = 0; r < MAT_ROWS; r++) mem[r] <= '0;
    end else if (wr_en) begin
      if (int'(wr_row) < MAT_ROWS) mem[wr_row] <= wr_data;
    end else if (swap_en && (int'(swap_a) < MAT_ROWS) && (int'(swap_b) < MAT_ROWS)) begin
      // Both sides read pre-edge values, so this is a true exchange.
      mem[swap_a] <= mem[swap_b];
      mem[swap_b] <= mem[swap_a];
    end
  end

  always_comb begin
    rd_data = '0;
    if (int'(rd_row) < MAT_ROWS) rd_data = mem[rd_row];
  end

  always_comb begin
    col_data = '0;
    for (int r = 0; r < MAT_ROWS; r++)
      col_data[r*COL_BITS +: COL_BITS] = mem[r][int'(col_sel)*COL_BITS +: COL_BITS];
  end

endmodule

// File: rtl/ame_pivot_ctrl.sv
// Purpose : partial-pivot row ordering for a 6x6 system; asks an external comparator for the pivot row per column and swaps rows.
// Latency : start to done_o = 6*(2+L)+1 cycles, L = comp_init_o to comp_done_i delay (L>=1).
// Backpressure: waits indefinitely in WAIT for comp_done_i; start_i/load_en_i ignored while busy.
// Ports: load_* (row write, IDLE only), start_i/busy_o/done_o (control), comp_* (comparator handshake),
//        rd_row_i/rd_data_o (combinational row read), perm_o (row permutation), err_o/singular_o (sticky flags).
// Option : define AME_PIVOT_SINGULAR_CHK_EN to abort on a zero pivot value and raise singular_o.
module ame_pivot_ctrl
  import ame_pkg::*;
#(
  parameter int COMP_DATA_BITS     = ame_pkg::COMP_DATA_BITS,
  parameter int COMP_DATA_IDX_BITS = ame_pkg::COMP_DATA_IDX_BITS,
  parameter int MAT_COLS           = ame_pkg::MAT_COLS
) (
  input  logic                                clk_i,
  input  logic                                rst_n_i,
  input  logic                                load_en_i,
  input  logic [2:0]                          load_row_i,
  input  logic [MAT_COLS*COMP_DATA_BITS-1:0]  load_data_i,
  input  logic                                start_i,
  output logic                                busy_o,
  output logic                                done_o,
  output logic                                comp_init_o,
  output logic [6*COMP_DATA_BITS-1:0]         comp_data_o,
  output logic [5:0]                          comp_data_mask_o,
  input  logic                                comp_done_i,
  input  logic [COMP_DATA_BITS-1:0]           comp_data_i,
  input  logic [COMP_DATA_IDX_BITS-1:0]       comp_data_index_i,
  input  logic [2:0]                          rd_row_i,
  output logic [MAT_COLS*COMP_DATA_BITS-1:0]  rd_data_o,
  output logic [6*3-1:0]                      perm_o,
  output logic                                err_o,
  output logic                                singular_o
);

  state_t                          state_q, state_d;
  logic [2:0]                      k_q;
  logic [COMP_DATA_IDX_BITS-1:0]   p_q;
  logic                            err_q;
  logic [2:0]                      perm_q [MAT_ROWS];
  logic [6*COMP_DATA_BITS-1:0]     col_data;
  logic [5:0]                      mask_k;
  logic [2:0]                      p_row;
  logic                            p_ok, wr_en, swap_en, start_acc, sing_hit;

  assign start_acc = (state_q == ST_IDLE) && start_i;
  assign wr_en     = (state_q == ST_IDLE) && load_en_i;
  assign p_row     = 3'(p_q);
  // Rows above k are already fixed, so an index below k is as invalid as one past the end.
  assign p_ok      = (int'(p_q) < MAT_ROWS) && (int'(p_q) >= int'(k_q));
  assign swap_en   = (state_q == ST_SWAP) && p_ok && (p_row != k_q);

  ame_mat_regfile #(
    .COL_BITS (COMP_DATA_BITS),
    .N_COLS   (MAT_COLS)
  ) u_regfile (
    .clk_i    (clk_i),
    .rst_n_i  (rst_n_i),
    .wr_en    (wr_en),
    .wr_row   (load_row_i),
    .wr_data  (load_data_i),
    .rd_row   (rd_row_i),
    .rd_data  (rd_data_o),
    .swap_en  (swap_en),
    .swap_a   (k_q),
    .swap_b   (p_row),
    .col_sel  (k_q),
    .col_data (col_data)
  );

  always_comb begin
    mask_k = '0;
    for (int r = 0; r < MAT_ROWS; r++) mask_k[r] = (r < int'(k_q));
  end

  always_comb begin
    state_d          = state_q;
    busy_o           = 1'b0;
    done_o           = 1'b0;
    comp_init_o      = 1'b0;
    comp_data_o      = '0;
    comp_data_mask_o = '0;
    sing_hit         = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start_i) state_d = ST_ISSUE;
      end
      ST_ISSUE: begin
        busy_o           = 1'b1;
        comp_init_o      = 1'b1;
        comp_data_o      = col_data;
        comp_data_mask_o = mask_k;
        state_d          = ST_WAIT;
      end
      ST_WAIT: begin
        busy_o           = 1'b1;
        comp_data_o      = col_data;
        comp_data_mask_o = mask_k;
        if (comp_done_i) begin
`ifdef AME_PIVOT_SINGULAR_CHK_EN
          if (comp_data_i == '0) begin
            sing_hit = 1'b1;
            state_d  = ST_FIN;
          end else begin
            state_d  = ST_SWAP;
          end
`else
          state_d = ST_SWAP;
`endif
        end
      end
      ST_SWAP: begin
        busy_o  = 1'b1;
        state_d = (k_q == 3'd5) ? ST_FIN : ST_ISSUE;
      end
      ST_FIN: begin
        done_o  = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q <= ST_IDLE;
      k_q     <= '0;
      p_q     <= '0;
      err_q   <= 1'b0;
      for (int r = 0; r < MAT_ROWS; r++) perm_q[r] <= 3'(r);
    end else begin
      state_q <= state_d;
      if (start_acc) begin
        k_q   <= '0;
        err_q <= 1'b0;
        for (int r = 0; r < MAT_ROWS; r++) perm_q[r] <= 3'(r);
      end
      if ((state_q == ST_WAIT) && comp_done_i) p_q <= comp_data_index_i;
      if (state_q == ST_SWAP) begin
        if (!p_ok) begin
          err_q <= 1'b1;
        end else if (p_row != k_q) begin
          perm_q[k_q]   <= perm_q[p_row];
          perm_q[p_row] <= perm_q[k_q];
        end
        if (k_q != 3'd5) k_q <= k_q + 3'd1;
      end
    end
  end

`ifdef AME_PIVOT_SINGULAR_CHK_EN
  logic sing_q;
  always_ff @(posedge clk_i) begin
    if (!rst_n_i)       sing_q <= 1'b0;
    else if (start_acc) sing_q <= 1'b0;
    else if (sing_hit)  sing_q <= 1'b1;
  end
  assign singular_o = sing_q;
`else
  // Pivot value is only inspected by the singular check.
  logic unused_comp_data;
  assign unused_comp_data = ^{comp_data_i, sing_hit};
  assign singular_o       = 1'b0;
`endif

  assign err_o = err_q;

  always_comb begin
    perm_o = '0;
    for (int r = 0; r < MAT_ROWS; r++) perm_o[r*3 +: 3] = perm_q[r];
  end

endmodule

// File: doc/ame_pivot_ctrl.md
AME_PIVOT_CTRL -- requirements
Module: ame_pivot_ctrl

Interface
REQ-001 SHALL have parameter COMP_DATA_BITS, default 64, signed element width.
REQ-002 SHALL have parameter COMP_DATA_IDX_BITS, default 3, row-index width.
REQ-003 SHALL have parameter MAT_COLS, default 7, columns per row (6x6 system plus RHS).
REQ-004 clk_i  in  1  single clock; all logic rising-edge.
REQ-005 rst_n_i  in  1  reset, synchronous, active-low.
REQ-006 load_en_i  in  1  write one matrix row.
REQ-007 load_row_i  in  3  row address for the write, 0..5.
REQ-008 load_data_i  in  MAT_COLS*COMP_DATA_BITS  row data, column 0 in the LSBs.
REQ-009 start_i  in  1  begin pivoting.
REQ-010 busy_o  out  1  high from start until done.
REQ-011 done_o  out  1  one-cycle completion pulse.
REQ-012 comp_init_o  out  1  one-cycle request to the comparator.
REQ-013 comp_data_o  out  6*COMP_DATA_BITS  column k of rows 0..5.
REQ-014 comp_data_mask_o  out  6  bit r=1 excludes row r.
REQ-015 comp_done_i  in  1  comparator result valid.
REQ-016 comp_data_i  in  COMP_DATA_BITS  selected pivot value.
REQ-017 comp_data_index_i  in  COMP_DATA_IDX_BITS  selected row.
REQ-018 rd_row_i  in  3 / rd_data_o  out  MAT_COLS*COMP_DATA_BITS  combinational read of the current row.
REQ-019 perm_o  out  6*3  perm_o[k] = original row now at position k.
REQ-020 err_o / singular_o  out  1 each  sticky flags, cleared on start.

Function
REQ-021 States: IDLE, ISSUE, WAIT, SWAP, FIN.
REQ-022 IDLE: load_en_i writes a row; start_i clears k, err_o and singular_o, sets perm_o to identity, and moves to ISSUE.
REQ-023 ISSUE, 1 cycle: pulse comp_init_o; drive column k; mask bits [k-1:0]=1, others 0; move to WAIT.
REQ-024 WAIT: hold comp_data_o and the mask stable until comp_done_i.
REQ-025 SWAP, 1 cycle: swap row k with row p=comp_data_index_i and swap perm_o[k] with perm_o[p]; if p==k, make no change.
REQ-026 After SWAP: if k==5, go to FIN; otherwise increment k and go to ISSUE.
REQ-027 FIN, 1 cycle: pulse done_o, deassert busy_o, return to IDLE.
REQ-028 Latency: start to done_o = 6*(2+L)+1 cycles, where L = cycles from comp_init_o to comp_done_i (L>=1).
REQ-029 If p>5 or p is masked (p<k): set err_o, skip the swap, continue.
REQ-030 Ignore start_i and load_en_i while busy; ignore comp_done_i outside WAIT.
REQ-031 If load_en_i and start_i are both high in IDLE: perform the write first; the pivot sequence uses the new row.
REQ-032 Matrix contents are only permuted, never changed arithmetically; bit-exact.

Reset
REQ-033 While rst_n_i=0 at a clock edge: state=IDLE, k=0, matrix=0, perm_o=identity; busy_o, done_o, comp_init_o, err_o, singular_o all 0; comp_data_o=0; mask=0.
REQ-034 Reset mid-operation aborts the sequence with no done_o; a late comp_done_i is ignored.

Configuration
REQ-035 With macro AME_PIVOT_SINGULAR_CHK_EN defined: comp_data_i==0 in WAIT sets singular_o and goes directly to FIN, with no swap.
REQ-036 Without it: singular_o is tied 0 and zero pivots proceed normally.

Structure
REQ-037 Shared package ame_pkg SHALL hold: COMP_DATA_BITS, COMP_DATA_IDX_BITS, MAT_COLS, the row typedef, and the state enum.
REQ-038 Matrix storage plus row swap SHALL be sub-module ame_mat_regfile, with write, read, and swap(a,b) ports.

Verification
REQ-039 Identity matrix; model returns p=k with L=3 -> perm_o=0,1,2,3,4,5; done_o at cycle 31; err_o=0.
REQ-040 Model returns p=5 for k=0, otherwise p=k -> rows 0 and 5 exchanged; perm_o[0]=5, perm_o[5]=0.
REQ-041 At k=2 model returns p=1 (masked) -> err_o=1, no swap, done_o still pulses.
REQ-042 Macro defined; at k=3 comp_data_i=0 -> singular_o=1; done_o 1 cycle after comp_done_i; rows 3..5 unchanged.
REQ-043 rst_n_i=0 during WAIT at k=2, then comp_done_i -> no done_o; busy_o=0; perm_o=identity; matrix=0.
REQ-044 start_i pulsed while busy plus a spurious comp_done_i in ISSUE -> no restart; sequence count unchanged.
